// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control -- multi-cycle MIPS-style control unit.
//
// Sequences each instruction through IF, ID, EX, MEM and WB as needed and
// drives the write enables and datapath selects of a shared datapath.
// Outputs are combinational from the current state and the instruction
// fields. The datapath has no intermediate registers, so the EX selects
// (ALUctr, ALUSrc, ExtOp, RegDst, MemtoReg) stay valid through MEM and WB,
// where the memory access and register write-back depend on them.
//
// Parameters:
//   ILLEGAL_NOP  1: undecoded op/func retires as a NOP after ID
//                0: undecoded op/func parks the FSM in ERR until reset
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   op, func, Rt    instruction fields (Rt only used for REGIMM)
//   IRWr, PCWr, RegWr, MemWr               write enables
//   Branch, Jump, RegDst, ALUSrc,
//   MemtoReg, ExtOp                         datapath selects
//   ALUctr          ALU operation code
//   state           current state (IF=0 ID=1 EX=2 MEM=3 WB=4 ERR=7)
//   done            pulse in the final state of each instruction
//   illegal         pulse in ID for an undecoded instruction
// ---------------------------------------------------------------------------
module mc_control #(
    parameter bit ILLEGAL_NOP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic [4:0] Rt,
    output logic       IRWr,
    output logic       PCWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic       Branch,
    output logic       Jump,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       ExtOp,
    output logic [4:0] ALUctr,
    output logic [2:0] state,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_R, C_I, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR
    } cls_t;

    state_t     state_reg;
    cls_t       cls;
    logic [4:0] dec_alu;
    logic       dec_ext;

    // Instruction decode: class, ALU code and immediate extension mode.
    always_comb begin
        cls     = C_ILL;
        dec_alu = 5'd0;
        dec_ext = 1'b0;
        case (op)
            6'h00: begin
                cls = C_R;
                if (func[5:3] == 3'b100) begin
                    // func 20..27 map straight onto ALU codes 0..7
                    dec_alu = {2'b00, func[2:0]};
                end else begin
                    case (func)
                        6'h2A:   dec_alu = 5'd8;
                        6'h2B:   dec_alu = 5'd9;
                        6'h00:   dec_alu = 5'd10;
                        6'h02:   dec_alu = 5'd11;
                        6'h03:   dec_alu = 5'd12;
                        6'h04:   dec_alu = 5'd14;
                        6'h06:   dec_alu = 5'd15;
                        6'h07:   dec_alu = 5'd16;
                        6'h08:   cls = C_JR;
                        default: cls = C_ILL;
                    endcase
                end
            end
            6'h01: begin
                // REGIMM: only bltz (Rt=0) and bgez (Rt=1) are decoded
                if (Rt == 5'd0 || Rt == 5'd1) begin
                    cls     = C_BR;
                    dec_alu = 5'd3;
                    dec_ext = 1'b1;
                end
            end
            6'h02: cls = C_J;
            6'h03: cls = C_JAL;
            6'h04, 6'h05: begin
                cls     = C_BR;
                dec_alu = 5'd3;
                dec_ext = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                cls = C_I;
                case (op[2:0])
                    3'd0:    begin dec_alu = 5'd0; dec_ext = 1'b1; end
                    3'd1:    begin dec_alu = 5'd1; dec_ext = 1'b1; end
                    3'd2:    begin dec_alu = 5'd8; dec_ext = 1'b1; end
                    3'd3:    begin dec_alu = 5'd9; dec_ext = 1'b1; end
                    3'd4:    dec_alu = 5'd4;
                    3'd5:    dec_alu = 5'd5;
                    3'd6:    dec_alu = 5'd6;
                    default: dec_alu = 5'd13;
                endcase
            end
            6'h23: begin
                cls     = C_LW;
                dec_alu = 5'd1;
                dec_ext = 1'b1;
            end
            6'h2B: begin
                cls     = C_SW;
                dec_alu = 5'd1;
                dec_ext = 1'b1;
            end
            default: cls = C_ILL;
        endcase
    end

    // State register and transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IF;
        end else begin
            case (state_reg)
                S_IF: state_reg <= S_ID;
                S_ID: begin
                    case (cls)
                        C_J, C_JAL, C_JR: state_reg <= S_IF;
                        C_ILL:            state_reg <= ILLEGAL_NOP ? S_IF : S_ERR;
                        default:          state_reg <= S_EX;
                    endcase
                end
                S_EX: begin
                    case (cls)
                        C_BR:       state_reg <= S_IF;
                        C_LW, C_SW: state_reg <= S_MEM;
                        default:    state_reg <= S_WB;
                    endcase
                end
                S_MEM:   state_reg <= (cls == C_SW) ? S_IF : S_WB;
                S_WB:    state_reg <= S_IF;
                S_ERR:   state_reg <= S_ERR;
                default: state_reg <= S_IF;  // unused encodings recover
            endcase
        end
    end

    logic ir_wr, pc_wr, reg_wr, mem_wr, illegal_ind;
    logic branch_sel, jump_sel, reg_dst, alu_src, mem_to_reg, ext_op;
    logic [4:0] alu_ctr;

    always_comb begin
        ir_wr       = 1'b0;
        pc_wr       = 1'b0;
        reg_wr      = 1'b0;
        mem_wr      = 1'b0;
        illegal_ind = 1'b0;
        branch_sel  = 1'b0;
        jump_sel    = 1'b0;
        reg_dst     = 1'b0;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        ext_op      = 1'b0;
        alu_ctr     = 5'd0;
        case (state_reg)
            S_IF: ir_wr = 1'b1;
            S_ID: begin
                if (cls == C_J || cls == C_JAL || cls == C_JR) begin
                    jump_sel = 1'b1;
                    pc_wr    = 1'b1;
                    reg_wr   = (cls == C_JAL);
                end
                if (cls == C_ILL) begin
                    illegal_ind = 1'b1;
                    pc_wr       = ILLEGAL_NOP;  // NOP retires here
                end
            end
            S_EX, S_MEM, S_WB: begin
                alu_ctr    = dec_alu;
                alu_src    = (cls == C_I) || (cls == C_LW) || (cls == C_SW);
                ext_op     = dec_ext;
                reg_dst    = (cls == C_R);
                mem_to_reg = (cls == C_LW);
                if (state_reg == S_EX && cls == C_BR) begin
                    branch_sel = 1'b1;
                    pc_wr      = 1'b1;
                end
                if (state_reg == S_MEM && cls == C_SW) begin
                    mem_wr = 1'b1;
                    pc_wr  = 1'b1;
                end
                if (state_reg == S_WB) begin
                    reg_wr = 1'b1;
                    pc_wr  = 1'b1;
                end
            end
            default: ;  // ERR and unused encodings drive nothing
        endcase
    end

    // Reset masks every side effect immediately, even before the state
    // register has been forced back to IF.
    assign IRWr     = ir_wr & ~rst;
    assign PCWr     = pc_wr & ~rst;
    assign RegWr    = reg_wr & ~rst;
    assign MemWr    = mem_wr & ~rst;
    assign done     = pc_wr & ~rst;
    assign illegal  = illegal_ind & ~rst;
    assign Branch   = branch_sel;
    assign Jump     = jump_sel;
    assign RegDst   = reg_dst;
    assign ALUSrc   = alu_src;
    assign MemtoReg = mem_to_reg;
    assign ExtOp    = ext_op;
    assign ALUctr   = alu_ctr;
    assign state    = state_reg;

endmodule

// File: tb/tb_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mc_control -- self-checking bench for mc_control.
// Two instances share op/func/Rt: u_nop (ILLEGAL_NOP=1) and u_err
// (ILLEGAL_NOP=0), each with its own reset. Every cycle both are compared
// against a reference built from instruction classes and their state paths.
// ---------------------------------------------------------------------------
module tb_mc_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_e;
    logic [5:0] op, func;
    logic [4:0] rt;

    logic irwr_n, pcwr_n, regwr_n, memwr_n, branch_n, jump_n, regdst_n;
    logic alusrc_n, memtoreg_n, extop_n, done_n, illegal_n;
    logic [4:0] aluctr_n;
    logic [2:0] state_n;
    logic irwr_e, pcwr_e, regwr_e, memwr_e, branch_e, jump_e, regdst_e;
    logic alusrc_e, memtoreg_e, extop_e, done_e, illegal_e;
    logic [4:0] aluctr_e;
    logic [2:0] state_e;

    mc_control #(.ILLEGAL_NOP(1'b1)) u_nop (
        .clk(clk), .rst(rst_n), .op(op), .func(func), .Rt(rt),
        .IRWr(irwr_n), .PCWr(pcwr_n), .RegWr(regwr_n), .MemWr(memwr_n),
        .Branch(branch_n), .Jump(jump_n), .RegDst(regdst_n), .ALUSrc(alusrc_n),
        .MemtoReg(memtoreg_n), .ExtOp(extop_n), .ALUctr(aluctr_n),
        .state(state_n), .done(done_n), .illegal(illegal_n)
    );

    mc_control #(.ILLEGAL_NOP(1'b0)) u_err (
        .clk(clk), .rst(rst_e), .op(op), .func(func), .Rt(rt),
        .IRWr(irwr_e), .PCWr(pcwr_e), .RegWr(regwr_e), .MemWr(memwr_e),
        .Branch(branch_e), .Jump(jump_e), .RegDst(regdst_e), .ALUSrc(alusrc_e),
        .MemtoReg(memtoreg_e), .ExtOp(extop_e), .ALUctr(aluctr_e),
        .state(state_e), .done(done_e), .illegal(illegal_e)
    );

    typedef struct packed {
        logic       irwr, pcwr, regwr, memwr, branch, jump;
        logic       regdst, alusrc, memtoreg, extop;
        logic [4:0] aluctr;
        logic [2:0] state;
        logic       done, illegal;
    } outs_t;

    outs_t act_n, act_e;
    assign act_n = {irwr_n, pcwr_n, regwr_n, memwr_n, branch_n, jump_n, regdst_n,
                    alusrc_n, memtoreg_n, extop_n, aluctr_n, state_n, done_n, illegal_n};
    assign act_e = {irwr_e, pcwr_e, regwr_e, memwr_e, branch_e, jump_e, regdst_e,
                    alusrc_e, memtoreg_e, extop_e, aluctr_e, state_e, done_e, illegal_e};

    localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4,
                   K_BR = 5, K_J = 6, K_JAL = 7, K_JR = 8;

    typedef struct {
        int         kind;
        logic [4:0] alu;
        logic       ext;
    } dec_t;

    int tests = 0;
    int fails = 0;

    // Reference decode written straight from the instruction table.
    function automatic dec_t decode(logic [5:0] o, logic [5:0] f, logic [4:0] r);
        dec_t d;
        logic [4:0] itab [8];
        logic [4:0] stab [8];
        itab = '{5'd0, 5'd1, 5'd8, 5'd9, 5'd4, 5'd5, 5'd6, 5'd13};
        stab = '{5'd10, 5'd0, 5'd11, 5'd12, 5'd14, 5'd0, 5'd15, 5'd16};
        d.kind = K_ILL; d.alu = 5'd0; d.ext = 1'b0;
        if (o == 6'h00) begin
            if (f >= 6'h20 && f <= 6'h27) begin d.kind = K_R; d.alu = 5'(f - 6'h20); end
            else if (f == 6'h2A) begin d.kind = K_R; d.alu = 5'd8; end
            else if (f == 6'h2B) begin d.kind = K_R; d.alu = 5'd9; end
            else if (f <= 6'h07 && f != 6'h01 && f != 6'h05) begin
                d.kind = K_R; d.alu = stab[f[2:0]];
            end
            else if (f == 6'h08) d.kind = K_JR;
        end else if (o == 6'h01) begin
            if (r <= 5'd1) begin d.kind = K_BR; d.alu = 5'd3; d.ext = 1'b1; end
        end else if (o == 6'h02) d.kind = K_J;
        else if (o == 6'h03) d.kind = K_JAL;
        else if (o == 6'h04 || o == 6'h05) begin d.kind = K_BR; d.alu = 5'd3; d.ext = 1'b1; end
        else if (o >= 6'h08 && o <= 6'h0F) begin
            d.kind = K_I; d.alu = itab[o - 6'h08]; d.ext = (o <= 6'h0B);
        end else if (o == 6'h23 || o == 6'h2B) begin
            d.kind = (o == 6'h23) ? K_LW : K_SW; d.alu = 5'd1; d.ext = 1'b1;
        end
        return d;
    endfunction

    // Cycles per instruction class.
    function automatic int seq_len(int kind);
        case (kind)
            K_LW:       return 5;
            K_SW, K_R, K_I: return 4;
            K_BR:       return 3;
            default:    return 2;
        endcase
    endfunction

    // State visited at step i of an instruction of the given class.
    function automatic int seq_state(int kind, int i);
        if (i <= 2) return i;
        if (i == 3) return (kind == K_LW || kind == K_SW) ? 3 : 4;
        return 4;
    endfunction

    function automatic outs_t exp_out(dec_t d, int st, bit last, logic r);
        outs_t e;
        bit jk;
        e = '0;
        e.state   = st[2:0];
        jk        = (d.kind == K_J || d.kind == K_JAL || d.kind == K_JR);
        e.irwr    = (st == 0);
        e.jump    = (st == 1) && jk;
        e.branch  = (st == 2) && (d.kind == K_BR);
        e.regwr   = (st == 4) || (st == 1 && d.kind == K_JAL);
        e.memwr   = (st == 3) && (d.kind == K_SW);
        e.illegal = (st == 1) && (d.kind == K_ILL);
        e.pcwr    = last && (st != 7);
        e.done    = e.pcwr;
        if (st >= 2 && st <= 4) begin
            e.aluctr   = d.alu;
            e.extop    = d.ext;
            e.regdst   = (d.kind == K_R);
            e.memtoreg = (d.kind == K_LW);
            e.alusrc   = (d.kind == K_I || d.kind == K_LW || d.kind == K_SW);
        end
        if (r) begin
            e.irwr = 0; e.pcwr = 0; e.regwr = 0; e.memwr = 0; e.done = 0; e.illegal = 0;
        end
        return e;
    endfunction

    task automatic check_out(input string name, input outs_t act, input outs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d) op=%h func=%h rt=%h",
                     name, act, act.state, exp, exp.state, op, func, rt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from IF; reports measured latency and the
    // {illegal_seen, ALUctr, RegDst, ALUSrc, ExtOp, MemtoReg} seen in EX.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                             output int lat, output logic [9:0] cap);
        dec_t d;
        int len, i, st_n, st_e;
        logic ill_seen;
        d = decode(o, f, r);
        len = seq_len(d.kind);
        op = o; func = f; rt = r;
        cap = '0; ill_seen = 1'b0;
        for (i = 0; i < 8; i++) begin
            if (i > 0 && state_n == 3'd0) break;
            st_n = (i < len) ? seq_state(d.kind, i) : 0;
            st_e = (i < len) ? st_n : ((d.kind == K_ILL) ? 7 : 0);
            #1;
            check_out("cycle_nop", act_n, exp_out(d, st_n, i == len - 1, rst_n));
            check_out("cycle_err", act_e, exp_out(d, st_e, (i == len - 1) && d.kind != K_ILL, rst_e));
            ill_seen = ill_seen | illegal_n;
            if (state_n == 3'd2)
                cap[8:0] = {aluctr_n, regdst_n, alusrc_n, extop_n, memtoreg_n};
            step();
        end
        cap[9] = ill_seen;
        lat = i;
        $display("[TB] op=%h func=%h rt=%h cycles=%0d", o, f, r, lat);
        if (d.kind == K_ILL) begin
            // err instance must sit in ERR; nop instance is held in reset
            rst_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
                #1;
                check_out("hold_nop", act_n, exp_out(d, 0, 0, 1'b1));
                check_out("err_hold", act_e, exp_out(d, 7, 0, 1'b0));
                step();
            end
            rst_e = 1'b1;
            #1;
            check_out("err_rst", act_e, exp_out(d, 7, 0, 1'b1));
            step();
            rst_n = 1'b0; rst_e = 1'b0;
        end
    endtask

    // Asserts reset on both instances at step 'at' of an instruction.
    task automatic rst_mid(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r, input int at);
        dec_t d;
        int len;
        d = decode(o, f, r);
        len = seq_len(d.kind);
        op = o; func = f; rt = r;
        for (int i = 0; i < at; i++) begin
            #1;
            check_out("pre_rst_nop", act_n, exp_out(d, seq_state(d.kind, i), i == len - 1, 1'b0));
            check_out("pre_rst_err", act_e, exp_out(d, seq_state(d.kind, i), i == len - 1, 1'b0));
            step();
        end
        rst_n = 1'b1; rst_e = 1'b1;
        #1;
        check_out("in_rst_nop", act_n, exp_out(d, seq_state(d.kind, at), at == len - 1, 1'b1));
        check_out("in_rst_err", act_e, exp_out(d, seq_state(d.kind, at), at == len - 1, 1'b1));
        step();
        rst_n = 1'b0; rst_e = 1'b0;
        #1;
        check_out("post_rst_nop", act_n, exp_out(d, 0, 0, 1'b0));
        check_out("post_rst_err", act_e, exp_out(d, 0, 0, 1'b0));
        $display("[TB] reset at step %0d of op=%h", at, o);
    endtask

    typedef struct {
        string      name;
        logic [5:0] op, func;
        logic [4:0] rt;
        int         lat;
        logic [9:0] sel;  // {illegal, ALUctr, RegDst, ALUSrc, ExtOp, MemtoReg} in EX
    } vec_t;

    function automatic vec_t mk(string n, logic [5:0] o, logic [5:0] f, logic [4:0] r,
                                int l, logic ill, logic [4:0] a, logic rd, logic src,
                                logic ext, logic m2r);
        vec_t v;
        v.name = n; v.op = o; v.func = f; v.rt = r; v.lat = l;
        v.sel = {ill, a, rd, src, ext, m2r};
        return v;
    endfunction

    initial begin
        vec_t vecs [$];
        int lat;
        logic [9:0] cap;
        logic [5:0] ops [16];
        logic [5:0] rf, ro;

        vecs.push_back(mk("lw",    6'h23, 6'h00, 5'd0, 5, 0, 5'd1,  0, 1, 1, 1));
        vecs.push_back(mk("sw",    6'h2B, 6'h00, 5'd0, 4, 0, 5'd1,  0, 1, 1, 0));
        vecs.push_back(mk("slt",   6'h00, 6'h2A, 5'd0, 4, 0, 5'd8,  1, 0, 0, 0));
        vecs.push_back(mk("sra",   6'h00, 6'h03, 5'd0, 4, 0, 5'd12, 1, 0, 0, 0));
        vecs.push_back(mk("add",   6'h00, 6'h20, 5'd0, 4, 0, 5'd0,  1, 0, 0, 0));
        vecs.push_back(mk("nor",   6'h00, 6'h27, 5'd0, 4, 0, 5'd7,  1, 0, 0, 0));
        vecs.push_back(mk("sltu",  6'h00, 6'h2B, 5'd0, 4, 0, 5'd9,  1, 0, 0, 0));
        vecs.push_back(mk("sll",   6'h00, 6'h00, 5'd0, 4, 0, 5'd10, 1, 0, 0, 0));
        vecs.push_back(mk("srl",   6'h00, 6'h02, 5'd0, 4, 0, 5'd11, 1, 0, 0, 0));
        vecs.push_back(mk("sllv",  6'h00, 6'h04, 5'd0, 4, 0, 5'd14, 1, 0, 0, 0));
        vecs.push_back(mk("srav",  6'h00, 6'h07, 5'd0, 4, 0, 5'd16, 1, 0, 0, 0));
        vecs.push_back(mk("addi",  6'h08, 6'h00, 5'd0, 4, 0, 5'd0,  0, 1, 1, 0));
        vecs.push_back(mk("sltiu", 6'h0B, 6'h00, 5'd0, 4, 0, 5'd9,  0, 1, 1, 0));
        vecs.push_back(mk("andi",  6'h0C, 6'h00, 5'd0, 4, 0, 5'd4,  0, 1, 0, 0));
        vecs.push_back(mk("xori",  6'h0E, 6'h00, 5'd0, 4, 0, 5'd6,  0, 1, 0, 0));
        vecs.push_back(mk("lui",   6'h0F, 6'h00, 5'd0, 4, 0, 5'd13, 0, 1, 0, 0));
        vecs.push_back(mk("beq",   6'h04, 6'h00, 5'd0, 3, 0, 5'd3,  0, 0, 1, 0));
        vecs.push_back(mk("bne",   6'h05, 6'h00, 5'd0, 3, 0, 5'd3,  0, 0, 1, 0));
        vecs.push_back(mk("bgez",  6'h01, 6'h00, 5'd1, 3, 0, 5'd3,  0, 0, 1, 0));
        vecs.push_back(mk("bltz",  6'h01, 6'h00, 5'd0, 3, 0, 5'd3,  0, 0, 1, 0));
        vecs.push_back(mk("j",     6'h02, 6'h00, 5'd0, 2, 0, 5'd0,  0, 0, 0, 0));
        vecs.push_back(mk("jal",   6'h03, 6'h00, 5'd0, 2, 0, 5'd0,  0, 0, 0, 0));
        vecs.push_back(mk("jr",    6'h00, 6'h08, 5'd0, 2, 0, 5'd0,  0, 0, 0, 0));
        vecs.push_back(mk("ill3f", 6'h3F, 6'h00, 5'd0, 2, 1, 5'd0,  0, 0, 0, 0));
        vecs.push_back(mk("illfn", 6'h00, 6'h05, 5'd0, 2, 1, 5'd0,  0, 0, 0, 0));
        vecs.push_back(mk("illrt", 6'h01, 6'h00, 5'd2, 2, 1, 5'd0,  0, 0, 0, 0));

        // Reset state
        rst_n = 1'b1; rst_e = 1'b1; op = '0; func = '0; rt = '0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_nop", act_n, exp_out(decode(6'h00, 6'h20, 5'd0), 0, 0, 1'b1));
        check_out("reset_err", act_e, exp_out(decode(6'h00, 6'h20, 5'd0), 0, 0, 1'b1));
        rst_n = 1'b0; rst_e = 1'b0;

        // Directed decode table
        foreach (vecs[k]) begin
            run_instr(vecs[k].op, vecs[k].func, vecs[k].rt, lat, cap);
            tests++;
            if (lat != vecs[k].lat) begin
                fails++;
                $display("FAIL latency_%s: got %0d expected %0d", vecs[k].name, lat, vecs[k].lat);
            end
            tests++;
            if (cap !== vecs[k].sel) begin
                fails++;
                $display("FAIL ex_sel_%s: got %h expected %h", vecs[k].name, cap, vecs[k].sel);
            end
        end

        // Reset mid-instruction: lw in every state (MEM included), sw in EX
        for (int at = 0; at < 5; at++) begin
            rst_mid(6'h23, 6'h00, 5'd0, at);
            run_instr(6'h23, 6'h00, 5'd0, lat, cap);
        end
        rst_mid(6'h2B, 6'h00, 5'd0, 2);
        run_instr(6'h00, 6'h2A, 5'd0, lat, cap);

        // Randomised instruction stream
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        for (int n = 0; n < 80; n++) begin
            ro = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 15)];
            rf = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(32, 43)) : 6'($urandom_range(0, 63));
            run_instr(ro, rf, 5'($urandom_range(0, 2)), lat, cap);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
